// File: rtl/mem_pkg.sv
// Shared types for the burst reader: FSM state encoding and FIFO sizing.
// No logic; no latency; no flow control.
package mem_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} burst_state_t;

    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/mem_burst_reader_fifo.sv
// Two-entry FIFO decoupling memory reads from the output stream.
// Latency: push visible at head next cycle. Backpressure: push accepted when not full or popping.
module stream_fifo2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] slot_q [2];
    logic [WIDTH-1:0] slot_d [2];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             push_ok, pop_ok;

    assign empty     = (count_q == 2'd0);
    assign full      = (count_q == 2'd2);
    assign count     = count_q;
    assign head_data = slot_q[rd_ptr_q];

    // When full, the write slot is the head slot; a simultaneous pop frees it this cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        slot_d   = slot_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (push_ok) begin
            slot_d[wr_ptr_q] = push_data;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        slot_q <= slot_d;
    end

endmodule

// File: rtl/mem_burst_reader.sv
// Reads base..base+len-1 from a combinational-read memory and streams the words in order.
// Latency: go -> first beat 2 cycles. Backpressure: reads stall while the 2-entry FIFO is full.
module mem_burst_reader
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SIZE       = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  go,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] mem_addr0,
    output logic                  mem_write_en,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam logic [ADDR_WIDTH+1:0] SIZE_W = (ADDR_WIDTH+2)'(SIZE);

    burst_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
    logic                  reject_q, reject_d;

    logic                  fifo_push, fifo_pop;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic [1:0]            fifo_count;
    logic                  fifo_full, fifo_empty;
    logic [ADDR_WIDTH+1:0] end_addr;

    assign end_addr  = {2'b00, base} + {1'b0, len};
    assign fifo_pop  = !fifo_empty && out_ready;
    assign fifo_push = (state_q == RUN) && (!fifo_full || fifo_pop);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        reject_d    = reject_q;
        case (state_q)
            IDLE: begin
                if (go) begin
                    ptr_d       = base;
                    remaining_d = len;
                    reject_d    = (end_addr > SIZE_W);
                    if (end_addr > SIZE_W || len == '0) begin
                        state_d = FIN;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (fifo_push) begin
                    remaining_d = remaining_q - 1'b1;
                    // ptr stays on the final word so mem_addr0 holds the last address in DRAIN.
                    if (remaining_q == 1) begin
                        state_d = DRAIN;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (fifo_empty || (fifo_count == 2'd1 && fifo_pop)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            reject_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            reject_q    <= reject_d;
        end
    end

    stream_fifo2 #(
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (mem_read_data),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign busy           = (state_q != IDLE);
    assign done           = (state_q == FIN);
    assign error          = (state_q == FIN) && reject_q;
    assign mem_addr0      = ptr_q;
    assign mem_write_en   = 1'b0;
    assign mem_write_data = '0;
    assign out_valid      = !fifo_empty;
    assign out_data       = fifo_head;

endmodule

// File: tb/tb_mem_burst_reader.sv
// Directed bench for mem_burst_reader: queue-based reference of expected words plus literal timing checks.
module tb_mem_burst_reader;

    localparam int DW   = 32;
    localparam int SIZE = 16;
    localparam int AW   = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          go;
    logic [AW-1:0] base;
    logic [AW:0]   len;
    logic          busy, done, error;
    logic [AW-1:0] mem_addr0;
    logic          mem_write_en;
    logic [DW-1:0] mem_write_data;
    logic [DW-1:0] mem_read_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    logic [DW-1:0] mem [SIZE];
    assign mem_read_data = mem[mem_addr0];

    always #5 clk = ~clk;

    mem_burst_reader #(
        .DATA_WIDTH (DW),
        .SIZE       (SIZE),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .go             (go),
        .base           (base),
        .len            (len),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .mem_addr0      (mem_addr0),
        .mem_write_en   (mem_write_en),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready)
    );

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] exp_q [$];
    logic          exp_active = 1'b0;
    logic          exp_err    = 1'b0;
    logic          checking   = 1'b0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;

    int            beat_cyc [32];
    logic [DW-1:0] beat_dat [32];
    int            nbeats;
    int            done_cyc;
    logic          done_err;
    logic          got_done;
    logic [AW-1:0] addr_at8;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic ready_for(input int mode, input int c);
        case (mode)
            1:       return (c % 2) == 0;
            2:       return c >= 10;
            default: return 1'b1;
        endcase
    endfunction

    // Reference: every cycle, compare the stream and done/error against the expected-word queue.
    always @(negedge clk) begin
        if (checking && !reset) begin
            if (busy) begin
                check("mem_write_en", mem_write_en, 0);
                check("mem_write_data", mem_write_data, 0);
                if (!done) check("error_only_with_done", error, 0);
            end
            if (out_valid) begin
                if (prev_stall) check("stall_stable", out_data, prev_data);
                if (exp_q.size() == 0) begin
                    check("spurious_beat", out_valid, 0);
                end else begin
                    check("beat_data", out_data, exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (done) begin
                check("done_when_active", done, exp_active);
                check("done_queue_empty", exp_q.size(), 0);
                check("done_error", error, exp_err);
                exp_active = 1'b0;
            end
        end
    end

    task automatic run_burst(input logic [AW-1:0] b, input logic [AW:0] l, input int mode,
                             input bit inject_go, input bit rst_after2);
        int reset_cyc;
        reset_cyc = -1;
        nbeats    = 0;
        done_cyc  = -1;
        done_err  = 1'b0;
        got_done  = 1'b0;
        addr_at8  = '0;
        base      = b;
        len       = l;
        go        = 1'b1;
        out_ready = ready_for(mode, 0);
        exp_active = 1'b1;
        exp_err    = (int'(b) + int'(l)) > SIZE;
        if (!exp_err) begin
            for (int i = 0; i < int'(l); i++) exp_q.push_back(mem[int'(b) + i]);
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid && out_ready && !reset) begin
                beat_cyc[nbeats] = c;
                beat_dat[nbeats] = out_data;
                nbeats++;
            end
            if (c == 8) addr_at8 = mem_addr0;
            if (done) begin
                done_cyc = c;
                done_err = error;
                got_done = 1'b1;
            end
            if (reset_cyc >= 0 && c == reset_cyc + 1) begin
                check("post_reset_out_valid", out_valid, 0);
                check("post_reset_busy", busy, 0);
            end
            if (reset_cyc >= 0 && c > reset_cyc) check("no_done_after_reset", done, 0);
            @(posedge clk);
            #1;
            go = inject_go && (c + 1 == 3);
            if (go) begin
                base = '0;
                len  = 5'd16;
            end
            out_ready = ready_for(mode, c + 1);
            if (rst_after2 && nbeats == 2 && reset_cyc < 0) begin
                reset     = 1'b1;
                out_ready = 1'b0;
                reset_cyc = c + 1;
            end else if (reset) begin
                reset = 1'b0;
                exp_q.delete();
                exp_active = 1'b0;
                prev_stall = 1'b0;
            end
            if (got_done || (reset_cyc >= 0 && c + 1 >= reset_cyc + 5)) break;
        end
        if (!rst_after2) check("burst_done_timeout", got_done, 1);
        go = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < SIZE; i++) mem[i] = DW'(i + 100);
        reset     = 1'b1;
        go        = 1'b0;
        base      = '0;
        len       = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_error", error, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_mem_addr0", mem_addr0, 0);
        check("reset_write_en", mem_write_en, 0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        checking = 1'b1;

        // Basic burst, consumer always ready
        run_burst(4'd2, 5'd4, 0, 1'b0, 1'b0);
        check("t1_nbeats", nbeats, 4);
        for (int k = 0; k < 4; k++) begin
            check("t1_beat_cyc", beat_cyc[k], 2 + k);
            check("t1_beat_dat", beat_dat[k], 102 + k);
        end
        check("t1_done_cyc", done_cyc, 6);
        check("t1_done_err", done_err, 0);

        // Toggling ready 1,0,1,0...
        run_burst(4'd2, 5'd4, 1, 1'b0, 1'b0);
        check("t2_nbeats", nbeats, 4);
        for (int k = 0; k < 4; k++) begin
            check("t2_beat_cyc", beat_cyc[k], 2 + 2 * k);
            check("t2_beat_dat", beat_dat[k], 102 + k);
        end
        check("t2_done_cyc", done_cyc, 9);

        // Ready low for 10 cycles, then high
        run_burst(4'd2, 5'd4, 2, 1'b0, 1'b0);
        check("t3_addr_stall", addr_at8, 4);
        check("t3_nbeats", nbeats, 4);
        for (int k = 0; k < 4; k++) begin
            check("t3_beat_cyc", beat_cyc[k], 10 + k);
            check("t3_beat_dat", beat_dat[k], 102 + k);
        end
        check("t3_done_cyc", done_cyc, 14);

        // Out of bounds: rejected
        run_burst(4'd12, 5'd5, 0, 1'b0, 1'b0);
        check("t4_nbeats", nbeats, 0);
        check("t4_done_cyc", done_cyc, 1);
        check("t4_done_err", done_err, 1);

        // Exactly reaching the last word is legal
        run_burst(4'd12, 5'd4, 0, 1'b0, 1'b0);
        check("t5_nbeats", nbeats, 4);
        check("t5_last_dat", beat_dat[3], 115);
        check("t5_done_err", done_err, 0);

        // Zero length
        run_burst(4'd5, 5'd0, 0, 1'b0, 1'b0);
        check("t6_nbeats", nbeats, 0);
        check("t6_done_cyc", done_cyc, 1);
        check("t6_done_err", done_err, 0);

        // Whole memory
        run_burst(4'd0, 5'd16, 0, 1'b0, 1'b0);
        check("t7_nbeats", nbeats, 16);
        check("t7_first_dat", beat_dat[0], 100);
        check("t7_last_dat", beat_dat[15], 115);
        check("t7_done_cyc", done_cyc, 18);

        // Reset after the 2nd beat, then a clean burst
        run_burst(4'd2, 5'd4, 0, 1'b0, 1'b1);
        check("t8_nbeats", nbeats, 2);
        check("t8_no_done", got_done, 0);
        run_burst(4'd2, 5'd4, 0, 1'b0, 1'b0);
        check("t8_clean_nbeats", nbeats, 4);
        check("t8_clean_first", beat_dat[0], 102);
        check("t8_clean_done_cyc", done_cyc, 6);

        // go during RUN is ignored
        run_burst(4'd2, 5'd4, 0, 1'b1, 1'b0);
        check("t9_nbeats", nbeats, 4);
        check("t9_last_dat", beat_dat[3], 105);
        check("t9_done_cyc", done_cyc, 6);
        @(negedge clk);
        check("t9_idle_after", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
